// File: rtl/f_pc_pkg.sv
// rtl/f_pc_pkg.sv - shared encodings and default constants for the fetch PC generator
package f_pc_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Redirect sources; a lower code means a higher priority.
  typedef enum logic [1:0] {
    SRC_REQ  = 2'd0,
    SRC_ERET = 2'd1,
    SRC_BR   = 2'd2,
    SRC_SEQ  = 2'd3
  } src_t;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_TEXT_LO    = 32'h0000_3000;
  localparam logic [31:0] DEF_TEXT_HI    = 32'h0000_6FFF;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;

  // A newer redirect replaces an older one when it is at least as urgent.
  function automatic logic takes_over(input src_t new_src, input src_t old_src);
    return new_src <= old_src;
  endfunction

endpackage

// File: rtl/f_pc_redirect_buf.sv
// rtl/f_pc_redirect_buf.sv - one-entry redirect target/priority holding register
//  clk, rst          : clock, asynchronous active-high reset
//  set, set_target,
//  set_src           : offer a redirect; accepted if empty or at least as urgent as the held one
//  clr               : drop the held redirect (wins over set)
//  vld, target, src  : held redirect
module f_pc_redirect_buf
  import f_pc_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set,
  input  logic          clr,
  input  logic [AW-1:0] set_target,
  input  logic [1:0]    set_src,
  output logic          vld,
  output logic [AW-1:0] target,
  output logic [1:0]    src
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= 1'b0;
      target <= '0;
      src    <= SRC_SEQ;
    end else if (clr) begin
      vld <= 1'b0;
    end else if (set && (!vld || takes_over(src_t'(set_src), src_t'(src)))) begin
      vld    <= 1'b1;
      target <= set_target;
      src    <= set_src;
    end
  end

endmodule

// File: rtl/f_pc_gen.sv
// rtl/f_pc_gen.sv - fetch-stage PC generator with redirect buffering and AdEL detection
//  clk, reset        : clock, asynchronous active-high reset
//  stall             : hazard stall, holds the PC (req/eret override it)
//  req               : exception/interrupt, redirect to HANDLER_PC
//  eret, epc         : return from exception to epc
//  br_taken,
//  br_target         : resolved taken branch/jump
//  imem_ready        : imem accepts the current pc
//  pc, pc_valid      : fetch address and its qualifier
//  ex_adel           : fetch address error for the current pc
//  pending           : a redirect is buffered and not yet applied
module f_pc_gen
  import f_pc_pkg::*;
#(
  parameter int            AW          = 32,
  parameter logic [AW-1:0] RESET_PC    = AW'(DEF_RESET_PC),
  parameter logic [AW-1:0] TEXT_LO     = AW'(DEF_TEXT_LO),
  parameter logic [AW-1:0] TEXT_HI     = AW'(DEF_TEXT_HI),
  parameter logic [AW-1:0] HANDLER_PC  = AW'(DEF_HANDLER_PC),
  parameter bit            ERET_BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          req,
  input  logic          eret,
  input  logic [AW-1:0] epc,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          imem_ready,
  output logic [AW-1:0] pc,
  output logic          pc_valid,
  output logic          ex_adel,
  output logic          pending
);

  state_t        state, state_nx;
  logic [AW-1:0] pc_r, pc_nx;

  logic          in_vld;
  src_t          in_src;
  logic [AW-1:0] in_tgt;
  logic [AW-1:0] pc_seq;
  logic          bypass;

  logic          buf_set, buf_clr, buf_vld;
  logic [AW-1:0] buf_tgt;
  logic [1:0]    buf_src;

  assign pc_seq = pc_r + AW'(4);

  // Incoming redirect of this cycle. A stalled branch is dropped: the hazard
  // unit re-asserts it once the stall clears.
  always_comb begin
    in_vld = 1'b1;
    in_src = SRC_REQ;
    in_tgt = HANDLER_PC;
    if (req) begin
      in_src = SRC_REQ;
      in_tgt = HANDLER_PC;
    end else if (eret) begin
      in_src = SRC_ERET;
      in_tgt = epc;
    end else if (br_taken && !stall) begin
      in_src = SRC_BR;
      in_tgt = br_target;
    end else begin
      in_vld = 1'b0;
      in_src = SRC_SEQ;
      in_tgt = pc_seq;
    end
  end

  // The bypass only applies when the eret can be taken at once in RUN; in
  // BOOT/HOLD or when imem is busy, epc goes through the normal path.
  assign bypass = ERET_BYPASS && (state == ST_RUN) && eret && !req && imem_ready;

  always_comb begin
    state_nx = state;
    pc_nx    = pc_r;
    buf_set  = 1'b0;
    buf_clr  = 1'b0;
    case (state)
      ST_BOOT: begin
        if (in_vld) begin
          buf_set  = 1'b1;
          state_nx = ST_HOLD;
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_vld) begin
          if (imem_ready) begin
            // With bypass, epc was fetched this cycle, so continue after it.
            pc_nx = bypass ? (epc + AW'(4)) : in_tgt;
          end else begin
            buf_set  = 1'b1;
            state_nx = ST_HOLD;
          end
        end else if (imem_ready && !stall) begin
          pc_nx = pc_seq;
        end
      end
      ST_HOLD: begin
        // A buffered redirect is committed: it applies as soon as imem takes
        // the current pc, unless an equally or more urgent one arrives now.
        if (imem_ready) begin
          if (in_vld && takes_over(in_src, src_t'(buf_src))) pc_nx = in_tgt;
          else                                               pc_nx = buf_tgt;
          buf_clr  = 1'b1;
          state_nx = ST_RUN;
        end else if (in_vld) begin
          buf_set = 1'b1;
        end
      end
      default: begin
        state_nx = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_BOOT;
      pc_r  <= RESET_PC;
    end else begin
      state <= state_nx;
      pc_r  <= pc_nx;
    end
  end

  f_pc_redirect_buf #(.AW(AW)) u_buf (
    .clk        (clk),
    .rst        (reset),
    .set        (buf_set),
    .clr        (buf_clr),
    .set_target (in_tgt),
    .set_src    (in_src),
    .vld        (buf_vld),
    .target     (buf_tgt),
    .src        (buf_src)
  );

  assign pc       = bypass ? epc : pc_r;
  assign pc_valid = (state != ST_BOOT);
  assign pending  = buf_vld;
  assign ex_adel  = pc_valid && !bypass &&
                    ((pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI));

endmodule

// File: tb/tb_f_pc_gen.sv
// tb/tb_f_pc_gen.sv - scoreboard bench for f_pc_gen against a behavioural fetch model
module tb_f_pc_gen;

  localparam logic [31:0] RST_PC  = 32'h0000_3000;
  localparam logic [31:0] LO      = 32'h0000_3000;
  localparam logic [31:0] HI      = 32'h0000_6FFF;
  localparam logic [31:0] HANDLER = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0, req = 1'b0, eret = 1'b0;
  logic [31:0] epc = '0, br_target = '0;
  logic        br_taken = 1'b0, imem_ready = 1'b0;
  logic [31:0] pc;
  logic        pc_valid, ex_adel, pending;

  f_pc_gen #(.AW(32), .ERET_BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret), .epc(epc),
    .br_taken(br_taken), .br_target(br_target), .imem_ready(imem_ready),
    .pc(pc), .pc_valid(pc_valid), .ex_adel(ex_adel), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic        v, a, p;
  } exp_t;
  exp_t q[$];

  // Behavioural model: "booted" flag, architectural pc, and an optional
  // remembered redirect (target + urgency, 0 = most urgent).
  bit          m_boot;
  logic [31:0] m_pc;
  bit          m_has;
  int          m_urg;
  logic [31:0] m_tgt;

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a < LO) || (a > HI);
  endfunction

  task automatic model_step();
    exp_t e;
    bit          have, byp;
    int          urg;
    logic [31:0] tgt;
    if (reset) begin
      m_boot = 1; m_pc = RST_PC; m_has = 0;
      e.pc = RST_PC; e.v = 0; e.a = 0; e.p = 0;
      q.push_back(e);
      return;
    end
    have = 1; urg = 0; tgt = HANDLER;
    if (req)                  begin urg = 0; tgt = HANDLER;   end
    else if (eret)            begin urg = 1; tgt = epc;       end
    else if (br_taken && !stall) begin urg = 2; tgt = br_target; end
    else have = 0;
    byp = !m_boot && !m_has && eret && !req && imem_ready;
    e.pc = byp ? epc : m_pc;
    e.v  = !m_boot;
    e.a  = e.v && !byp && bad_addr(e.pc);
    e.p  = m_has;
    q.push_back(e);
    if (m_boot) begin
      if (have) begin m_has = 1; m_urg = urg; m_tgt = tgt; end
      m_boot = 0;
    end else if (m_has) begin
      if (imem_ready) begin
        m_pc  = (have && urg <= m_urg) ? tgt : m_tgt;
        m_has = 0;
      end else if (have && urg <= m_urg) begin
        m_urg = urg; m_tgt = tgt;
      end
    end else if (have) begin
      if (imem_ready) m_pc = byp ? epc + 32'd4 : tgt;
      else begin m_has = 1; m_urg = urg; m_tgt = tgt; end
    end else if (imem_ready && !stall) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit rq, input bit er, input logic [31:0] ep,
                     input bit b, input logic [31:0] bt, input bit rd);
    @(posedge clk); #1;
    reset = r; stall = s; req = rq; eret = er; epc = ep;
    br_taken = b; br_target = bt; imem_ready = rd;
    model_step();
  endtask

  // Spot check of the current cycle's outputs against spec constants.
  task automatic look(input string name, input logic [31:0] e_pc, input bit e_v, input bit e_a, input bit e_p);
    @(negedge clk); #2;
    chk({name, ".pc"}, pc, e_pc);
    chk({name, ".valid"}, {31'b0, pc_valid}, {31'b0, e_v});
    chk({name, ".adel"}, {31'b0, ex_adel}, {31'b0, e_a});
    chk({name, ".pending"}, {31'b0, pending}, {31'b0, e_p});
  endtask

  // Monitor: compare every cycle's outputs with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb.pc", pc, e.pc);
        chk("sb.valid", {31'b0, pc_valid}, {31'b0, e.v});
        chk("sb.adel", {31'b0, ex_adel}, {31'b0, e.a});
        chk("sb.pending", {31'b0, pending}, {31'b0, e.p});
      end
    end
  end

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return LO + 32'd4 * $urandom_range(0, 32'hFFF);
      1:       return LO + 32'd4 * $urandom_range(0, 32'hFFF) + 32'($urandom_range(1, 3));
      2:       return 32'h0000_6FFC;
      3:       return 32'h0000_7000;
      4:       return 32'h0000_2FFC;
      default: return 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    // Reset and boot bubble.
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    look("reset", 32'h3000, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    look("boot", 32'h3000, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    look("run0", 32'h3000, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    look("run1", 32'h3004, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    look("run2", 32'h3008, 1, 0, 0);
    // Branch under back-pressure.
    cyc(0, 0, 0, 0, 0, 1, 32'h3400, 0);
    look("br_busy", 32'h300C, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    look("hold", 32'h300C, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    look("br_applied", 32'h3400, 1, 0, 0);
    // req + eret under stall: req wins.
    cyc(0, 1, 1, 1, 32'h3010, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    look("req_wins", 32'h4180, 1, 0, 0);
    // eret bypass.
    cyc(0, 0, 0, 1, 32'h3020, 0, 0, 1);
    look("eret_byp", 32'h3020, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    look("eret_next", 32'h3024, 1, 0, 0);
    // Address errors.
    cyc(0, 0, 0, 0, 0, 1, 32'h3002, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    look("adel_misal", 32'h3002, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h7000, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    look("adel_hi", 32'h7000, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h6FFC, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    look("last_legal", 32'h6FFC, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    look("seq_off_end", 32'h7000, 1, 1, 0);
    // Async reset while holding a redirect.
    cyc(0, 0, 0, 0, 0, 1, 32'h3400, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    look("hold2", 32'h7000, 1, 1, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst.pending", {31'b0, pending}, 32'd0);
    chk("async_rst.pc", pc, 32'h3000);
    chk("async_rst.valid", {31'b0, pc_valid}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    look("after_rst", 32'h3000, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 11) == 0,
          pick_addr(),
          $urandom_range(0, 4) == 0,
          pick_addr(),
          $urandom_range(0, 3) != 0);
    end

    repeat (2) @(posedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
